// File: rtl/arbiter_iob.sv
// N-port request arbiter with registered one-hot and binary grants.
// Fixed-priority or round-robin selection, optional hold on request or acknowledge.
module arbiter_iob #(
  parameter int unsigned PORTS                = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN = 0,
  parameter int unsigned ARB_BLOCK            = 0,
  parameter int unsigned ARB_BLOCK_ACK        = 1,
  parameter string       LSB_PRIORITY         = "LOW",
  parameter int unsigned ENC_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [ENC_W-1:0] grant_encoded
);

  localparam bit HighPrio   = (LSB_PRIORITY == "HIGH");
  localparam bit RoundRobin = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam bit Block      = (ARB_BLOCK != 0);
  localparam bit BlockAck   = (ARB_BLOCK_ACK != 0);

  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [ENC_W-1:0] enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic [PORTS-1:0] masked, sel_vec, rr_mask;
  logic [ENC_W-1:0] sel_idx;
  logic             req_hit, ack_hit, hold;

  // "HIGH": index 0 wins; "LOW": highest index wins.
  function automatic logic [ENC_W-1:0] prio_enc(input logic [PORTS-1:0] vec);
    logic [ENC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      int k;
      k = HighPrio ? (int'(PORTS) - 1 - i) : i;
      if (vec[k]) idx = ENC_W'(k);
    end
    return idx;
  endfunction

  always_comb begin
    req_hit = |(grant_q & request);
    ack_hit = |(grant_q & acknowledge);
    hold    = Block && valid_q && (BlockAck ? !ack_hit : req_hit);

    masked  = request & mask_q;
    sel_vec = (RoundRobin && (masked != '0)) ? masked : request;
    sel_idx = prio_enc(sel_vec);

    // Next mask favours the ports after the winner in rotation order.
    rr_mask = '0;
    for (int j = 0; j < int'(PORTS); j++) begin
      rr_mask[j] = HighPrio ? (j > int'(sel_idx)) : (j < int'(sel_idx));
    end
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    if (!hold) begin
      if (request != '0) begin
        grant_d = PORTS'(1) << sel_idx;
        valid_d = 1'b1;
        enc_d   = sel_idx;
        if (RoundRobin) mask_d = rr_mask;
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;

endmodule
